// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin owner of the shared_memory write and read ports.
// Writes are granted as bursts of up to BURST_LEN beats with one idle cycle between
// bursts. Reads are granted one unit per cycle. A read is held back while its unit is
// the write owner and is actively writing, so the read cannot return pre-write data.
// Optional build macro: SHARED_ARB_STATS_EN adds the stat_wr_beats and
// stat_rd_conflicts saturating counters.
`timescale 1ns/1ps
module shared_mem_arbiter #(
  parameter int unsigned NUM_UNITS = 32,
  parameter int unsigned ID_W      = $clog2(NUM_UNITS),
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_UNITS-1:0]        wr_req,
  input  logic [NUM_UNITS*DATA_W-1:0] wr_data,
  output logic [NUM_UNITS-1:0]        wr_gnt,
  input  logic [NUM_UNITS-1:0]        rd_req,
  output logic [NUM_UNITS-1:0]        rd_gnt,
  output logic [NUM_UNITS-1:0]        rd_valid,
  output logic [ID_W-1:0]             write_unit_id,
  output logic                        write_enable,
  output logic [DATA_W-1:0]           write_data,
  output logic [ID_W-1:0]             read_unit_id,
  output logic                        busy
`ifdef SHARED_ARB_STATS_EN
  ,
  output logic [31:0]                 stat_wr_beats,
  output logic [31:0]                 stat_rd_conflicts
`endif
);

  // Wide enough for BURST_LEN up to 16.
  localparam int unsigned CntW = 5;
  localparam logic [CntW-1:0] BurstLast = CntW'(BURST_LEN - 1);

  typedef enum logic [0:0] {StWIdle, StWBurst} wr_state_e;

  // Returns {found, id} of the first set bit of req at or after ptr, wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_UNITS-1:0] req,
                                            input logic [ID_W-1:0]      ptr);
    logic              found;
    logic [ID_W-1:0]   sel;
    logic [ID_W-1:0]   cand;
    int unsigned       idx;
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      idx  = (32'(ptr) + i) % NUM_UNITS;
      cand = ID_W'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    return {found, sel};
  endfunction

  // Unit id following id, wrapping at NUM_UNITS-1.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (32'(id) == NUM_UNITS - 1) return '0;
    return id + 1'b1;
  endfunction

  wr_state_e            state_q, state_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [NUM_UNITS-1:0] wr_gnt_q, wr_gnt_d;
  logic [CntW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ID_W:0]        wr_pick;

  logic [NUM_UNITS-1:0] rd_gnt_q, rd_gnt_d;
  logic [NUM_UNITS-1:0] rd_valid_q;
  logic [ID_W-1:0]      read_unit_id_q, read_unit_id_d;
  logic [ID_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [NUM_UNITS-1:0] rd_mask;
  logic [NUM_UNITS-1:0] rd_elig;
  logic [ID_W:0]        rd_pick;

  // Write FSM next state; write_enable follows the owner's request within a burst.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_gnt_d     = wr_gnt_q;
    beat_cnt_d   = beat_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    write_enable = 1'b0;
    wr_pick      = rr_pick(wr_req, wr_ptr_q);
    case (state_q)
      StWIdle: begin
        if (wr_pick[ID_W]) begin
          owner_d    = wr_pick[ID_W-1:0];
          wr_gnt_d   = NUM_UNITS'(1) << wr_pick[ID_W-1:0];
          beat_cnt_d = '0;
          state_d    = StWBurst;
        end
      end
      StWBurst: begin
        write_enable = wr_req[owner_q];
        if (write_enable) beat_cnt_d = beat_cnt_q + 1'b1;
        // A dropped request ends the burst without consuming a beat.
        if (!write_enable || beat_cnt_q == BurstLast) begin
          wr_gnt_d = '0;
          wr_ptr_d = next_id(owner_q);
          state_d  = StWIdle;
        end
      end
      default: state_d = StWIdle;
    endcase
  end

  // Write state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StWIdle;
      owner_q    <= '0;
      wr_gnt_q   <= '0;
      beat_cnt_q <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wr_gnt_q   <= wr_gnt_d;
      beat_cnt_q <= beat_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Read arbitration, skipping the unit currently being written.
  always_comb begin
    rd_mask        = write_enable ? (NUM_UNITS'(1) << owner_q) : '0;
    rd_elig        = rd_req & ~rd_mask;
    rd_pick        = rr_pick(rd_elig, rd_ptr_q);
    rd_gnt_d       = '0;
    read_unit_id_d = read_unit_id_q;
    rd_ptr_d       = rd_ptr_q;
    if (rd_pick[ID_W]) begin
      rd_gnt_d       = NUM_UNITS'(1) << rd_pick[ID_W-1:0];
      read_unit_id_d = rd_pick[ID_W-1:0];
      rd_ptr_d       = next_id(rd_pick[ID_W-1:0]);
    end
  end

  // Read registers; rd_valid trails rd_gnt by the memory read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_gnt_q       <= '0;
      rd_valid_q     <= '0;
      read_unit_id_q <= '0;
      rd_ptr_q       <= '0;
    end else begin
      rd_gnt_q       <= rd_gnt_d;
      rd_valid_q     <= rd_gnt_q;
      read_unit_id_q <= read_unit_id_d;
      rd_ptr_q       <= rd_ptr_d;
    end
  end

  // Write data mux; owner resets to 0 so the output stays X-free.
  always_comb begin
    write_data = '0;
    for (int k = 0; k < int'(NUM_UNITS); k++) begin
      if (owner_q == ID_W'(k)) write_data = wr_data[k*DATA_W +: DATA_W];
    end
  end

  assign wr_gnt        = wr_gnt_q;
  assign rd_gnt        = rd_gnt_q;
  assign rd_valid      = rd_valid_q;
  assign write_unit_id = owner_q;
  assign read_unit_id  = read_unit_id_q;
  assign busy          = (state_q == StWBurst);

`ifdef SHARED_ARB_STATS_EN
  logic [31:0] stat_wr_beats_q;
  logic [31:0] stat_rd_conflicts_q;
  logic        rd_conflict;

  assign rd_conflict = write_enable & rd_req[owner_q];

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wr_beats_q     <= '0;
      stat_rd_conflicts_q <= '0;
    end else begin
      if (write_enable && stat_wr_beats_q != 32'hFFFF_FFFF) begin
        stat_wr_beats_q <= stat_wr_beats_q + 32'd1;
      end
      if (rd_conflict && stat_rd_conflicts_q != 32'hFFFF_FFFF) begin
        stat_rd_conflicts_q <= stat_rd_conflicts_q + 32'd1;
      end
    end
  end

  assign stat_wr_beats     = stat_wr_beats_q;
  assign stat_rd_conflicts = stat_rd_conflicts_q;
`else
  // No statistics hardware in the default build.
`endif

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: cycle tables for write bursts and the read hazard,
// a queue-based scoreboard for read rotation, and hand-written reset sequences.
`timescale 1ns/1ps
module tb_shared_mem_arbiter;
  localparam int unsigned N   = 32;
  localparam int unsigned IDW = 5;
  localparam int unsigned DW  = 256;
  localparam int unsigned BL  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      wr_req;
  logic [N*DW-1:0]   wr_data;
  logic [N-1:0]      wr_gnt;
  logic [N-1:0]      rd_req;
  logic [N-1:0]      rd_gnt;
  logic [N-1:0]      rd_valid;
  logic [IDW-1:0]    write_unit_id;
  logic              write_enable;
  logic [DW-1:0]     write_data;
  logic [IDW-1:0]    read_unit_id;
  logic              busy;
`ifdef SHARED_ARB_STATS_EN
  logic [31:0]       stat_wr_beats;
  logic [31:0]       stat_rd_conflicts;
`endif

  int errors = 0;
  int checks = 0;

  shared_mem_arbiter #(
    .NUM_UNITS(N),
    .ID_W(IDW),
    .DATA_W(DW),
    .BURST_LEN(BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_req(wr_req),
    .wr_data(wr_data),
    .wr_gnt(wr_gnt),
    .rd_req(rd_req),
    .rd_gnt(rd_gnt),
    .rd_valid(rd_valid),
    .write_unit_id(write_unit_id),
    .write_enable(write_enable),
    .write_data(write_data),
    .read_unit_id(read_unit_id),
    .busy(busy)
`ifdef SHARED_ARB_STATS_EN
    ,
    .stat_wr_beats(stat_wr_beats),
    .stat_rd_conflicts(stat_rd_conflicts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          rst_before;
    logic [31:0] wr_req;
    logic [31:0] rd_req;
    logic [31:0] e_wgnt;
    logic        e_we;
    logic [4:0]  e_wid;
    logic        e_busy;
    logic [31:0] e_rgnt;
    logic [31:0] e_rv;
    logic [4:0]  e_rid;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_word(input int k);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(k);
    return {8{w}};
  endfunction

  task automatic add(input bit rb, input logic [31:0] w, input logic [31:0] r,
                     input logic [31:0] eg, input logic ewe, input logic [4:0] ewid,
                     input logic eb, input logic [31:0] erg, input logic [31:0] erv,
                     input logic [4:0] erid);
    vec_t v;
    v = '{rb, w, r, eg, ewe, ewid, eb, erg, erv, erid};
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    wr_req = '0;
    rd_req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [31:0] U31 = 32'h8000_0000;
  localparam logic [31:0] U30 = 32'h4000_0000;
  localparam logic [31:0] U37 = 32'h0000_0088;

  int g_id_q[$];
  int g_cyc_q[$];
  int v_id_q[$];
  int v_cyc_q[$];
  int seq[5] = '{2, 9, 20, 2, 9};
  int id;
  int cy;

  initial begin
    for (int k = 0; k < int'(N); k++) wr_data[k*DW +: DW] = data_word(k);

    // Reset with every request high: all outputs stay low.
    rst    = 1'b1;
    wr_req = '1;
    rd_req = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset wr_gnt", wr_gnt, 0);
    check("reset rd_gnt", rd_gnt, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset write_enable", write_enable, 0);
    check("reset write_unit_id", write_unit_id, 0);
    check("reset read_unit_id", read_unit_id, 0);
    check("reset busy", busy, 0);
    check("reset write_data", write_data[63:0], data_word(0) & 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("release wr_gnt", wr_gnt, 64'h1);
    check("release write_enable", write_enable, 1);
    check("release rd_gnt", rd_gnt, 64'h1);
    check("release read_unit_id", read_unit_id, 0);

    // Units 3 and 7 alternate 4-beat bursts; final burst ended by request drop.
    add(1, U37, 0, 0,      0, 0, 0, 0, 0, 0);
    add(0, U37, 0, 32'h8,  1, 3, 1, 0, 0, 0);
    add(0, U37, 0, 32'h8,  1, 3, 1, 0, 0, 0);
    add(0, U37, 0, 32'h8,  1, 3, 1, 0, 0, 0);
    add(0, U37, 0, 32'h8,  1, 3, 1, 0, 0, 0);
    add(0, U37, 0, 0,      0, 3, 0, 0, 0, 0);
    add(0, U37, 0, 32'h80, 1, 7, 1, 0, 0, 0);
    add(0, U37, 0, 32'h80, 1, 7, 1, 0, 0, 0);
    add(0, U37, 0, 32'h80, 1, 7, 1, 0, 0, 0);
    add(0, U37, 0, 32'h80, 1, 7, 1, 0, 0, 0);
    add(0, U37, 0, 0,      0, 7, 0, 0, 0, 0);
    add(0, U37, 0, 32'h8,  1, 3, 1, 0, 0, 0);
    add(0, 0,   0, 32'h8,  0, 3, 1, 0, 0, 0);
    add(0, 0,   0, 0,      0, 3, 0, 0, 0, 0);
    // Unit 31 writes 2 beats then drops; pointer wraps so unit 0 beats unit 30;
    // unit 30 drops before its turn and is never granted.
    add(1, U31,       0, 0,   0, 0,  0, 0, 0, 0);
    add(0, U31,       0, U31, 1, 31, 1, 0, 0, 0);
    add(0, U31 | 1,   0, U31, 1, 31, 1, 0, 0, 0);
    add(0, 1,         0, U31, 0, 31, 1, 0, 0, 0);
    add(0, U30 | 1,   0, 0,   0, 31, 0, 0, 0, 0);
    add(0, U30 | 1,   0, 1,   1, 0,  1, 0, 0, 0);
    add(0, U30,       0, 1,   0, 0,  1, 0, 0, 0);
    add(0, 0,         0, 0,   0, 0,  0, 0, 0, 0);
    add(0, 0,         0, 0,   0, 0,  0, 0, 0, 0);
    // Unit 5 writing while units 5 and 6 read: 6 first, 5 only after the write stops.
    add(1, 32'h20, 0,      0,      0, 0, 0, 0,      0,      0);
    add(0, 32'h20, 32'h60, 32'h20, 1, 5, 1, 0,      0,      0);
    add(0, 32'h20, 32'h20, 32'h20, 1, 5, 1, 32'h40, 0,      6);
    add(0, 32'h20, 32'h20, 32'h20, 1, 5, 1, 0,      32'h40, 6);
    add(0, 0,      32'h20, 32'h20, 0, 5, 1, 0,      0,      6);
    add(0, 0,      0,      0,      0, 5, 0, 32'h20, 0,      5);
    add(0, 0,      0,      0,      0, 5, 0, 0,      32'h20, 5);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) do_reset();
      @(posedge clk);
      #1;
      wr_req = tbl[i].wr_req;
      rd_req = tbl[i].rd_req;
      @(negedge clk);
      check($sformatf("row%0d wr_gnt", i), wr_gnt, tbl[i].e_wgnt);
      check($sformatf("row%0d write_enable", i), write_enable, tbl[i].e_we);
      check($sformatf("row%0d write_unit_id", i), write_unit_id, tbl[i].e_wid);
      check($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
      check($sformatf("row%0d rd_gnt", i), rd_gnt, tbl[i].e_rgnt);
      check($sformatf("row%0d rd_valid", i), rd_valid, tbl[i].e_rv);
      check($sformatf("row%0d read_unit_id", i), read_unit_id, tbl[i].e_rid);
    end
`ifdef SHARED_ARB_STATS_EN
    check("stat_wr_beats", stat_wr_beats, 3);
    check("stat_rd_conflicts", stat_rd_conflicts, 3);
`endif

    // Units 2, 9, 20 hold rd_req: grants rotate, rd_valid one cycle behind.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (c < 5) begin
        rd_req = 32'h0010_0204;
        g_id_q.push_back(seq[c]);
        g_cyc_q.push_back(c + 1);
        v_id_q.push_back(seq[c]);
        v_cyc_q.push_back(c + 2);
      end else begin
        rd_req = '0;
      end
      @(negedge clk);
      if (rd_gnt != 0) begin
        if (g_id_q.size() == 0) begin
          check("rr unexpected rd_gnt", rd_gnt, 0);
        end else begin
          id = g_id_q.pop_front();
          cy = g_cyc_q.pop_front();
          check("rr rd_gnt", rd_gnt, 64'(1) << id);
          check("rr read_unit_id", read_unit_id, 64'(id));
          check("rr rd_gnt cycle", 64'(c), 64'(cy));
        end
      end
      if (rd_valid != 0) begin
        if (v_id_q.size() == 0) begin
          check("rr unexpected rd_valid", rd_valid, 0);
        end else begin
          id = v_id_q.pop_front();
          cy = v_cyc_q.pop_front();
          check("rr rd_valid", rd_valid, 64'(1) << id);
          check("rr rd_valid cycle", 64'(c), 64'(cy));
        end
      end
    end
    check("rr grants outstanding", 64'(g_id_q.size()), 0);
    check("rr valids outstanding", 64'(v_id_q.size()), 0);

    // Reset mid-burst at beat 2; arbitration then restarts from unit 0.
    do_reset();
    @(posedge clk); #1; wr_req = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1; wr_req = 0;
    @(posedge clk); #1; wr_req = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midburst write_enable", write_enable, 1);
    check("midburst write_unit_id", write_unit_id, 6);
    check("midburst write_data", write_data[63:0], data_word(6) & 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    rst = 1'b1;
    #1;
    check("async rst write_enable", write_enable, 0);
    check("async rst wr_gnt", wr_gnt, 0);
    check("async rst busy", busy, 0);
    check("async rst write_unit_id", write_unit_id, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    wr_req = 32'h102;
    @(posedge clk);
    @(negedge clk);
    check("restart wr_gnt", wr_gnt, 64'h2);
    check("restart write_unit_id", write_unit_id, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
